// File: rtl/disp_arb_pkg.sv
// Shared types and constants for the display owner arbiter.
// DISP_ARB_BLANK_EN adds the BLANK state between owners.
package disp_arb_pkg;

    localparam int unsigned DEF_NREQ         = 4;
    localparam int unsigned DEF_BLANK_FRAMES = 2;
    localparam int unsigned DEF_PIX_W        = 16;

    // Idle drive for the OLED pixel bus (replicated across PIX_W) and the 7-seg.
    localparam logic       PIX_BLANK = 1'b0;
    localparam logic [3:0] AN_OFF    = 4'hF;
    localparam logic [7:0] SEG_OFF   = 8'hFF;

`ifdef DISP_ARB_BLANK_EN
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_OWN   = 2'd1,
        ST_BLANK = 2'd2
    } state_t;
`else
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_OWN  = 2'd1
    } state_t;
`endif

endpackage

// File: rtl/disp_owner_arbiter_rr_pick.sv
// Combinational round-robin picker: first active request after last_owner, wrapping.
module rr_pick #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned IDW  = 2
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  last_owner,
    output logic            valid,
    output logic [IDW-1:0]  index
);

    int unsigned cand;

    always_comb begin
        valid = 1'b0;
        index = '0;
        cand  = 0;
        for (int unsigned k = 1; k <= NREQ; k++) begin
            cand = (32'(last_owner) + k) % NREQ;
            if (!valid && req[cand[IDW-1:0]]) begin
                valid = 1'b1;
                index = cand[IDW-1:0];
            end
        end
    end

endmodule

// File: rtl/disp_owner_arbiter.sv
// Frame-synchronous owner arbiter for the shared OLED / 7-seg display.
// Optional macro DISP_ARB_BLANK_EN inserts BLANK_FRAMES blank frames on owner change.
module disp_owner_arbiter
    import disp_arb_pkg::*;
#(
    parameter int unsigned NREQ         = DEF_NREQ,
    parameter int unsigned BLANK_FRAMES = DEF_BLANK_FRAMES,
    parameter int unsigned PIX_W        = DEF_PIX_W
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     frame_begin,
    input  logic [NREQ-1:0]          req,
    input  logic [NREQ*PIX_W-1:0]    pix_in,
    input  logic [NREQ*4-1:0]        an_in,
    input  logic [NREQ*8-1:0]        seg_in,
    output logic [NREQ-1:0]          grant,
    output logic [$clog2(NREQ)-1:0]  owner_id,
    output logic [PIX_W-1:0]         pixel_data,
    output logic [3:0]               an,
    output logic [7:0]               seg,
    output logic                     busy
);

    localparam int unsigned IDW = $clog2(NREQ);

    if (BLANK_FRAMES < 1 || BLANK_FRAMES > 15) begin : g_bad_blank_frames
        $error("BLANK_FRAMES must be in 1..15");
    end

    state_t          state;
    logic [IDW-1:0]  last_owner;
    logic            pick_valid;
    logic [IDW-1:0]  pick_idx;
    logic [NREQ-1:0] pick_onehot;
    logic            owner_req;
    logic [PIX_W-1:0] sel_pix;
    logic [3:0]      sel_an;
    logic [7:0]      sel_seg;

`ifdef DISP_ARB_BLANK_EN
    logic [3:0]      blank_cnt;
`endif

    rr_pick #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_rr_pick (
        .req        (req),
        .last_owner (last_owner),
        .valid      (pick_valid),
        .index      (pick_idx)
    );

    always_comb begin
        pick_onehot           = '0;
        pick_onehot[pick_idx] = 1'b1;
    end

    assign owner_req = req[owner_id];

    always_comb begin
        sel_pix = '0;
        sel_an  = '0;
        sel_seg = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            if (owner_id == k[IDW-1:0]) begin
                sel_pix = pix_in[k*PIX_W +: PIX_W];
                sel_an  = an_in[k*4 +: 4];
                sel_seg = seg_in[k*8 +: 8];
            end
        end
    end

    // Requests are only looked at on frame_begin, so mid-frame glitches never move ownership.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            grant      <= '0;
            owner_id   <= '0;
            last_owner <= IDW'(NREQ - 1);
`ifdef DISP_ARB_BLANK_EN
            blank_cnt  <= '0;
            busy       <= 1'b0;
`endif
        end else if (frame_begin) begin
            case (state)
                ST_IDLE: begin
                    if (pick_valid) begin
                        state      <= ST_OWN;
                        grant      <= pick_onehot;
                        owner_id   <= pick_idx;
                        last_owner <= pick_idx;
                    end
                end
                ST_OWN: begin
                    if (!owner_req) begin
`ifdef DISP_ARB_BLANK_EN
                        state     <= ST_BLANK;
                        grant     <= '0;
                        blank_cnt <= 4'(BLANK_FRAMES);
                        busy      <= 1'b1;
`else
                        // Hand over on the release edge; the releasing owner's req is low so it cannot win.
                        if (pick_valid) begin
                            grant      <= pick_onehot;
                            owner_id   <= pick_idx;
                            last_owner <= pick_idx;
                        end else begin
                            state <= ST_IDLE;
                            grant <= '0;
                        end
`endif
                    end
                end
`ifdef DISP_ARB_BLANK_EN
                ST_BLANK: begin
                    if (blank_cnt == 4'd1) begin
                        blank_cnt <= '0;
                        busy      <= 1'b0;
                        if (pick_valid) begin
                            state      <= ST_OWN;
                            grant      <= pick_onehot;
                            owner_id   <= pick_idx;
                            last_owner <= pick_idx;
                        end else begin
                            state <= ST_IDLE;
                        end
                    end else begin
                        blank_cnt <= blank_cnt - 4'd1;
                    end
                end
`endif
                default: begin
                    state <= ST_IDLE;
                    grant <= '0;
                end
            endcase
        end
    end

`ifndef DISP_ARB_BLANK_EN
    assign busy = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pixel_data <= {PIX_W{PIX_BLANK}};
            an         <= AN_OFF;
            seg        <= SEG_OFF;
        end else if (state == ST_OWN) begin
            pixel_data <= sel_pix;
            an         <= sel_an;
            seg        <= sel_seg;
        end else begin
            pixel_data <= {PIX_W{PIX_BLANK}};
            an         <= AN_OFF;
            seg        <= SEG_OFF;
        end
    end

endmodule
